// File: rtl/instr_port_arb.sv
// Single instruction-memory port shared by fetch and store/SET-IR requesters.
// Combinational grant, starvation-bounded fetch, one-cycle tagged read return.
module instr_port_arb #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          f_req,
  input  logic [AW-1:0] f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          s_req,
  input  logic          s_we,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_wdata,
  output logic          s_gnt,
  output logic          s_rvalid,
  output logic [DW-1:0] s_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wen,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic [3:0]    starve_cnt
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic       r_last_f;
  logic [1:0] r_rd_tag;
  logic [3:0] r_starve_cnt;

  logic w_force;
  logic w_s_wr;
  logic w_f_win;
  logic w_f_gnt;
  logic w_s_gnt;

  always_comb begin
    w_force = f_req && (r_starve_cnt == LP_MAX_WAIT);
    w_s_wr  = s_req && s_we;
    w_f_win = 1'b0;
    if (w_force)
      w_f_win = 1'b1;
    else if (w_s_wr)
      w_f_win = 1'b0;
    else if (f_req && s_req)
      w_f_win = !r_last_f;
    else
      w_f_win = f_req;
    // grants are gated by reset so nothing reaches the memory while held in reset
    w_f_gnt = rst_n && w_f_win;
    w_s_gnt = rst_n && s_req && !w_f_win;
  end

  assign f_gnt      = w_f_gnt;
  assign s_gnt      = w_s_gnt;
  assign mem_addr   = w_f_gnt ? f_addr : (w_s_gnt ? s_addr : '0);
  assign mem_wdata  = w_s_gnt ? s_wdata : '0;
  assign mem_wen    = w_s_gnt && s_we;
  assign stall      = f_req && !w_f_gnt;
  assign starve_cnt = r_starve_cnt;

  assign f_rvalid = (r_rd_tag == 2'b11);
  assign s_rvalid = (r_rd_tag == 2'b10);
  assign f_rdata  = f_rvalid ? mem_rdata : '0;
  assign s_rdata  = s_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_tag     <= 2'b00;
      r_last_f     <= 1'b0;
      r_starve_cnt <= 4'd0;
    end else begin
      if (w_f_gnt || (w_s_gnt && !s_we))
        r_rd_tag <= {1'b1, w_f_gnt};
      else
        r_rd_tag <= 2'b00;

      if (w_f_gnt || w_s_gnt)
        r_last_f <= w_f_gnt;

      if (!f_req || w_f_gnt)
        r_starve_cnt <= 4'd0;
      else if (r_starve_cnt < LP_MAX_WAIT)
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_instr_port_arb.sv
// Directed bench for instr_port_arb: fetch-only read, lone write, starvation
// force-grant, alternating read ties, and reset in the middle of a read.
module tb_instr_port_arb;

  logic        clk;
  logic        rst_n;
  logic        f_req;
  logic [15:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [15:0] f_rdata;
  logic        s_req;
  logic        s_we;
  logic [15:0] s_addr;
  logic [15:0] s_wdata;
  logic        s_gnt;
  logic        s_rvalid;
  logic [15:0] s_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wen;
  logic [15:0] mem_rdata;
  logic        stall;
  logic [3:0]  starve_cnt;

  int n_pass;
  int n_total;

  instr_port_arb #(.AW(16), .DW(16), .MAX_WAIT(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .f_req      (f_req),
    .f_addr     (f_addr),
    .f_gnt      (f_gnt),
    .f_rvalid   (f_rvalid),
    .f_rdata    (f_rdata),
    .s_req      (s_req),
    .s_we       (s_we),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_gnt      (s_gnt),
    .s_rvalid   (s_rvalid),
    .s_rdata    (s_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .starve_cnt (starve_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: fixed contents, data one cycle after address
  always @(posedge clk) begin
    if (mem_addr == 16'h0010)
      mem_rdata <= 16'hBEEF;
    else if (mem_addr == 16'h0020)
      mem_rdata <= 16'h1234;
    else
      mem_rdata <= mem_addr ^ 16'h5A5A;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    f_req   = 1'b1;
    f_addr  = 16'h0010;
    s_req   = 1'b0;
    s_we    = 1'b0;
    s_addr  = 16'h0000;
    s_wdata = 16'h0000;

    // held in reset with a live fetch request
    @(negedge clk);
    #1;
    chk("rst_f_gnt", f_gnt, 0);
    chk("rst_s_gnt", s_gnt, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_f_rvalid", f_rvalid, 0);
    chk("rst_s_rvalid", s_rvalid, 0);
    chk("rst_starve", starve_cnt, 0);

    // fetch-only read
    @(negedge clk);
    rst_n  = 1'b1;
    f_req  = 1'b1;
    f_addr = 16'h0010;
    #1;
    chk("f_only_gnt", f_gnt, 1);
    chk("f_only_s_gnt", s_gnt, 0);
    chk("f_only_addr", mem_addr, 16'h0010);
    chk("f_only_stall", stall, 0);
    @(negedge clk);
    f_req = 1'b0;
    #1;
    chk("f_only_rvalid", f_rvalid, 1);
    chk("f_only_rdata", f_rdata, 16'hBEEF);
    chk("f_only_s_rvalid", s_rvalid, 0);

    // lone store write
    @(negedge clk);
    s_req   = 1'b1;
    s_we    = 1'b1;
    s_addr  = 16'h0040;
    s_wdata = 16'hCAFE;
    #1;
    chk("wr_s_gnt", s_gnt, 1);
    chk("wr_mem_wen", mem_wen, 1);
    chk("wr_mem_addr", mem_addr, 16'h0040);
    chk("wr_mem_wdata", mem_wdata, 16'hCAFE);
    @(negedge clk);
    s_req = 1'b0;
    #1;
    chk("wr_no_s_rvalid", s_rvalid, 0);
    chk("wr_no_f_rvalid", f_rvalid, 0);
    chk("wr_wen_one_cycle", mem_wen, 0);

    // fetch read starved by store write until forced
    @(negedge clk);
    f_req   = 1'b1;
    f_addr  = 16'h0010;
    s_req   = 1'b1;
    s_we    = 1'b1;
    s_addr  = 16'h0020;
    s_wdata = 16'h1234;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("starve_s_gnt_%0d", k), s_gnt, (k != 3) ? 1 : 0);
      chk($sformatf("starve_f_gnt_%0d", k), f_gnt, (k == 3) ? 1 : 0);
      chk($sformatf("starve_wen_%0d", k), mem_wen, (k != 3) ? 1 : 0);
      chk($sformatf("starve_cnt_%0d", k), starve_cnt, (k == 4) ? 0 : k);
      chk($sformatf("starve_stall_%0d", k), stall, (k != 3) ? 1 : 0);
      chk($sformatf("starve_addr_%0d", k), mem_addr, (k == 3) ? 16'h0010 : 16'h0020);
      chk($sformatf("starve_f_rvalid_%0d", k), f_rvalid, (k == 4) ? 1 : 0);
      if (k == 4) chk("starve_wdata_4", mem_wdata, 16'h1234);
      @(negedge clk);
    end

    // reset with a store write pending: no write may reach memory
    rst_n = 1'b0;
    f_req = 1'b0;
    #1;
    chk("rst2_s_gnt", s_gnt, 0);
    chk("rst2_mem_wen", mem_wen, 0);

    // both request reads every cycle from reset: F,S,F,S,F
    @(negedge clk);
    rst_n  = 1'b1;
    f_req  = 1'b1;
    f_addr = 16'h0010;
    s_req  = 1'b1;
    s_we   = 1'b0;
    s_addr = 16'h0020;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("tie_f_gnt_%0d", k), f_gnt, (k % 2 == 0) ? 1 : 0);
      chk($sformatf("tie_s_gnt_%0d", k), s_gnt, (k % 2 == 1) ? 1 : 0);
      chk($sformatf("tie_addr_%0d", k), mem_addr, (k % 2 == 0) ? 16'h0010 : 16'h0020);
      chk($sformatf("tie_f_rvalid_%0d", k), f_rvalid, (k % 2 == 1) ? 1 : 0);
      chk($sformatf("tie_f_rdata_%0d", k), f_rdata, (k % 2 == 1) ? 16'hBEEF : 16'h0000);
      chk($sformatf("tie_s_rvalid_%0d", k), s_rvalid, (k > 0 && k % 2 == 0) ? 1 : 0);
      chk($sformatf("tie_s_rdata_%0d", k), s_rdata, (k > 0 && k % 2 == 0) ? 16'h1234 : 16'h0000);
      @(negedge clk);
    end

    // fetch alone, then reset asserted the cycle after its grant
    s_req = 1'b0;
    #1;
    chk("mid_f_gnt", f_gnt, 1);
    @(negedge clk);
    #1;
    chk("mid_f_rvalid_pre", f_rvalid, 1);
    chk("mid_f_rdata_pre", f_rdata, 16'hBEEF);
    s_req = 1'b1;
    s_we  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_f_rvalid", f_rvalid, 0);
    chk("mid_rst_f_rdata", f_rdata, 0);
    chk("mid_rst_starve", starve_cnt, 0);
    chk("mid_rst_f_gnt", f_gnt, 0);
    chk("mid_rst_s_gnt", s_gnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_f_rvalid", f_rvalid, 0);
    chk("post_rst_s_rvalid", s_rvalid, 0);
    chk("post_rst_tie_f_gnt", f_gnt, 1);
    chk("post_rst_tie_s_gnt", s_gnt, 0);
    @(negedge clk);
    #1;
    chk("post_rst_f_rvalid2", f_rvalid, 1);
    chk("post_rst_f_rdata2", f_rdata, 16'hBEEF);
    chk("post_rst_s_gnt2", s_gnt, 1);
    f_req = 1'b0;
    s_req = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_port_arb.md
INSTR_PORT_ARB -- requirements
Module: instr_port_arb

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- AW, 16, address width.
- DW, 16, data width.
- MAX_WAIT, 3, consecutive denied fetch cycles before fetch is force-granted (range 1..15).

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, single clock; all state updates on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- f_req, in, 1, fetch read request.
- f_addr, in, AW, fetch address.
- f_gnt, out, 1, fetch granted this cycle.
- f_rvalid, out, 1, fetch read data valid.
- f_rdata, out, DW, fetch read data.
- s_req, in, 1, store/SET-IR requester request.
- s_we, in, 1, 1 = write, 0 = read.
- s_addr, in, AW, store address.
- s_wdata, in, DW, store write data.
- s_gnt, out, 1, store granted this cycle.
- s_rvalid, out, 1, store read data valid.
- s_rdata, out, DW, store read data.
- mem_addr, out, AW, instruction memory port address.
- mem_wdata, out, DW, instruction memory write data.
- mem_wen, out, 1, instruction memory write enable.
- mem_rdata, in, DW, memory read data, valid exactly 1 cycle after address.
- stall, out, 1, f_req & !f_gnt.
- starve_cnt, out, 4, current fetch denial count (debug).

Function
REQ-003 Arbitration SHALL be combinational from current inputs and registered state; at most one of f_gnt and s_gnt SHALL be 1 in any cycle.
REQ-004 A request is accepted in the cycle its gnt is 1; the requester SHALL hold req, addr, we and wdata stable until then; the block SHALL NOT require req to drop after grant.
REQ-005 Priority order:
- (a) if f_req and starve_cnt == MAX_WAIT, grant fetch;
- (b) else if s_req and s_we, grant store (writes first);
- (c) else if both request reads, grant the requester not granted last (last_gnt register, reset value = store, so fetch wins the first tie);
- (d) else grant the sole requester.
REQ-006 mem_addr and mem_wdata SHALL mux from the granted requester; mem_wen = s_gnt & s_we; with no grant, mem_addr SHALL be 0 and mem_wen 0.
REQ-007 Read tag register rd_tag[1:0] (bit1 = valid, bit0 = 1 for fetch) SHALL load {1, f_gnt} on any granted read, else 0.
REQ-008 Read return: f_rvalid = rd_tag == 2'b11 and s_rvalid = rd_tag == 2'b10, both one cycle after grant. f_rdata and s_rdata SHALL equal mem_rdata when their rvalid is 1, else 0.
REQ-009 Granted writes SHALL produce no rvalid.
REQ-010 Back-to-back grants every cycle SHALL be supported; the port SHALL be never idle while any req is high.
REQ-011 starve_cnt update:
- reset to 0 when f_gnt is 1 or f_req is 0;
- increment when f_req & !f_gnt;
- saturate at MAX_WAIT.
REQ-012 last_gnt SHALL update only on a cycle with a grant.
REQ-013 Forced fetch grant under (a) SHALL also override a pending store write; the write SHALL remain requested and be granted the next cycle if still highest priority.
REQ-014 Address wrap: no arithmetic on addresses; all AW bits pass through unchanged.

Reset
REQ-015 While rst_n = 0, asynchronously and independent of clk:
- registers: rd_tag = 0, starve_cnt = 0, last_gnt = store;
- outputs: f_rvalid, s_rvalid, f_rdata, s_rdata = 0; f_gnt, s_gnt, mem_wen = 0 (gnt outputs gated by rst_n).
REQ-016 A read granted in the cycle reset asserts SHALL produce no rvalid after reset release.
REQ-017 The first clock edge after rst_n rises SHALL be a normal arbitration cycle.

Verification
REQ-018 f_req only, f_addr = 0x0010, mem returns 0xBEEF -> f_gnt = 1, mem_addr = 0x0010; next cycle f_rvalid = 1, f_rdata = 0xBEEF, s_rvalid = 0.
REQ-019 f_req plus s_req write (s_addr = 0x0020, s_wdata = 0x1234) for 5 cycles -> s_gnt cycles 0-2, starve_cnt 1, 2, 3; cycle 3 f_gnt = 1, mem_wen = 0; cycle 4 s_gnt, mem_wen = 1, mem_wdata = 0x1234.
REQ-020 Both read every cycle from reset -> grants alternate F, S, F, S; rvalids alternate one cycle later with matching rdata.
REQ-021 s_req write alone -> mem_wen = 1 for 1 cycle, no s_rvalid, no f_rvalid.
REQ-022 rst_n driven low mid-read (the cycle after f_gnt) -> f_rvalid and f_rdata forced to 0 immediately; starve_cnt = 0; first grant after release is fetch on a read tie.
